// File: rtl/sram_sp_access_ctrl_pkg.sv
// Shared types for the single-port SRAM access controller: default widths,
// FSM states, write-request and macro-port structs.
package sram_ctrl_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 20;
  localparam int DEF_MASK_W = 10;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } state_e;

  // Bits of data covered by one write-mask bit.
  function automatic int granule_w(input int data_w, input int mask_w);
    return data_w / mask_w;
  endfunction

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
    logic [DEF_MASK_W-1:0] mask;
  } wreq_t;

  typedef struct packed {
    logic                  en;
    logic                  wmode;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_MASK_W-1:0] wmask;
    logic [DEF_DATA_W-1:0] wdata;
  } sram_port_t;

endpackage

// File: rtl/sram_sp_access_ctrl_if.sv
// Request/response channels between the table pipeline and the SRAM controller.
interface sram_sp_access_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 20,
  parameter int MASK_W = 10
);
  logic              w_req_valid;
  logic              w_req_ready;
  logic [ADDR_W-1:0] w_req_addr;
  logic [DATA_W-1:0] w_req_data;
  logic [MASK_W-1:0] w_req_mask;
  logic              r_req_valid;
  logic              r_req_ready;
  logic [ADDR_W-1:0] r_req_addr;
  logic              r_resp_valid;
  logic [DATA_W-1:0] r_resp_data;

  modport master (
    output w_req_valid, w_req_addr, w_req_data, w_req_mask,
    output r_req_valid, r_req_addr,
    input  w_req_ready, r_req_ready, r_resp_valid, r_resp_data
  );

  modport slave (
    input  w_req_valid, w_req_addr, w_req_data, w_req_mask,
    input  r_req_valid, r_req_addr,
    output w_req_ready, r_req_ready, r_resp_valid, r_resp_data
  );
endinterface

// File: rtl/sram_sp_access_ctrl_init_sweeper.sv
// Post-reset zero-fill: one full-mask write of zero per cycle, address 0..DEPTH-1,
// then parks in IDLE with done high until the next reset.
module sram_init_sweeper
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DEPTH   = 1 << DEF_ADDR_W,
  parameter int INIT_EN = 1
) (
  input  logic       clock,
  input  logic       reset,
  output sram_port_t port,
  output logic       done
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_e            state;
  logic [ADDR_W-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= (INIT_EN != 0) ? ST_INIT : ST_IDLE;
      cnt   <= '0;
    end else if (state == ST_INIT) begin
      cnt <= cnt + 1'b1;
      // The last address is still written this cycle; no second pass.
      if (cnt == LAST) state <= ST_IDLE;
    end
  end

  always_comb begin
    port = '0;
    if (state == ST_INIT) begin
      port.en    = 1'b1;
      port.wmode = 1'b1;
      port.addr  = cnt;
      port.wmask = '1;
    end
  end

  assign done = (state == ST_IDLE);
endmodule

// File: rtl/sram_sp_access_ctrl.sv
// Single-port SRAM access controller: zero-fill after reset, write-over-read
// arbitration, one-cycle read response with a hold register for the last read data.
module sram_sp_access_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DEPTH   = 1 << DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int MASK_W  = DEF_MASK_W,
  parameter int INIT_EN = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  sram_sp_access_ctrl_if.slave  bus,
  output logic                  init_done,
  output logic                  sram_en,
  output logic                  sram_wmode,
  output logic [ADDR_W-1:0]     sram_addr,
  output logic [MASK_W-1:0]     sram_wmask,
  output logic [DATA_W-1:0]     sram_wdata,
  input  logic [DATA_W-1:0]     sram_rdata
);
  sram_port_t        sweep_port, port;
  wreq_t             wreq;
  logic              sweep_done, idle;
  logic              w_ready, r_ready, w_fire, r_fire;
  logic              resp_pending;
  logic [DATA_W-1:0] hold_q;

  sram_init_sweeper #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .INIT_EN(INIT_EN)
  ) u_sweep (
    .clock(clock),
    .reset(reset),
    .port (sweep_port),
    .done (sweep_done)
  );

  // Everything visible is forced quiet while reset is held, whatever the state flops say.
  assign idle    = sweep_done && !reset;
  assign w_ready = idle;
  assign r_ready = idle && !bus.w_req_valid;
  assign w_fire  = bus.w_req_valid && w_ready;
  assign r_fire  = bus.r_req_valid && r_ready;
  assign wreq    = '{addr: bus.w_req_addr, data: bus.w_req_data, mask: bus.w_req_mask};

  always_comb begin
    port = '0;
    if (!reset) begin
      if (!sweep_done) begin
        port = sweep_port;
      end else if (w_fire) begin
        port.en    = 1'b1;
        port.wmode = 1'b1;
        port.addr  = wreq.addr;
        port.wmask = wreq.mask;
        port.wdata = wreq.data;
      end else if (r_fire) begin
        port.en   = 1'b1;
        port.addr = bus.r_req_addr;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      resp_pending <= 1'b0;
      hold_q       <= '0;
    end else begin
      resp_pending <= r_fire;
      if (resp_pending) hold_q <= sram_rdata;
    end
  end

  assign init_done        = idle;
  assign bus.w_req_ready  = w_ready;
  assign bus.r_req_ready  = r_ready;
  assign bus.r_resp_valid = resp_pending && !reset;
  // No bypass: writes never touch the returned data, only a read response does.
  assign bus.r_resp_data  = reset ? '0 : (resp_pending ? sram_rdata : hold_q);

  assign sram_en    = port.en;
  assign sram_wmode = port.wmode;
  assign sram_addr  = port.addr;
  assign sram_wmask = port.wmask;
  assign sram_wdata = port.wdata;
endmodule

// File: tb/tb_sram_sp_access_ctrl.sv
// Bench for sram_sp_access_ctrl: behavioural 256x20 macro, read scoreboard with
// latency check, vector table plus hand sequences for arbitration, hold and reset.
module tb_sram_sp_access_ctrl;
  logic        clock, reset;
  logic        init_done, sram_en, sram_wmode;
  logic [7:0]  sram_addr;
  logic [9:0]  sram_wmask;
  logic [19:0] sram_wdata, sram_rdata;
  logic [19:0] r_exp;

  sram_sp_access_ctrl_if bus ();

  sram_sp_access_ctrl dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .init_done (init_done),
    .sram_en   (sram_en),
    .sram_wmode(sram_wmode),
    .sram_addr (sram_addr),
    .sram_wmask(sram_wmask),
    .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Macro model; never-written entries read back as garbage so the zero-fill matters.
  logic [19:0] mem [256];
  bit   [255:0] written;
  always @(posedge clock) begin
    if (sram_en) begin
      if (sram_wmode) begin
        for (int g = 0; g < 10; g++)
          if (sram_wmask[g]) mem[sram_addr][2*g +: 2] <= sram_wdata[2*g +: 2];
        written[sram_addr] <= 1'b1;
      end else begin
        sram_rdata <= written[sram_addr] ? mem[sram_addr] : 20'hBAD5A;
      end
    end
  end

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct { logic [19:0] data; int due; } exp_t;
  exp_t        sb[$];
  int          cyc = 0;
  logic [19:0] exp_hold = '0;

  // Scoreboard: push on observed read fire, pop on response, check latency and hold.
  always @(negedge clock) begin
    exp_t e;
    cyc++;
    if (reset) begin
      sb.delete();
      exp_hold = '0;
      chk("rst_rvalid", bus.r_resp_valid, 0);
      chk("rst_rdata", bus.r_resp_data, 0);
    end else begin
      if (bus.r_resp_valid) begin
        if (sb.size() == 0) chk("resp_unexpected", bus.r_resp_valid, 0);
        else begin
          e = sb.pop_front();
          chk("resp_data", bus.r_resp_data, e.data);
          chk("resp_latency", cyc, e.due);
          exp_hold = e.data;
        end
      end else begin
        chk("hold_data", bus.r_resp_data, exp_hold);
        if (sb.size() != 0 && sb[0].due <= cyc) begin
          chk("resp_missing", bus.r_resp_valid, 1);
          void'(sb.pop_front());
        end
      end
      if (bus.r_req_valid && bus.r_req_ready) sb.push_back('{data: r_exp, due: cyc + 1});
    end
  end

  task automatic do_reset();
    @(posedge clock); #1;
    reset = 1'b1;
    bus.w_req_valid = 1'b0;
    bus.r_req_valid = 1'b0;
    @(negedge clock);
    chk("rst_sram_en", sram_en, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_w_ready", bus.w_req_ready, 0);
    chk("rst_r_ready", bus.r_req_ready, 0);
    @(posedge clock);
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic sweep_check(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      chk("sw_en", sram_en, 1);
      chk("sw_wmode", sram_wmode, 1);
      chk("sw_addr", sram_addr, i);
      chk("sw_wmask", sram_wmask, 10'h3FF);
      chk("sw_wdata", sram_wdata, 0);
      chk("sw_init_done", init_done, 0);
      chk("sw_w_ready", bus.w_req_ready, 0);
      chk("sw_r_ready", bus.r_req_ready, 0);
    end
  endtask

  task automatic post_init();
    @(negedge clock);
    chk("done_init_done", init_done, 1);
    chk("done_w_ready", bus.w_req_ready, 1);
    chk("done_r_ready", bus.r_req_ready, 1);
    chk("done_sram_en", sram_en, 0);
    @(posedge clock); #1;
  endtask

  // Called just after a rising edge; returns just after the edge that accepted the request.
  task automatic issue(input bit wr, input logic [7:0] a, input logic [19:0] d,
                       input logic [9:0] m, input logic [19:0] e);
    int waits = 0;
    if (wr) begin
      bus.w_req_valid = 1'b1; bus.w_req_addr = a; bus.w_req_data = d; bus.w_req_mask = m;
    end else begin
      bus.r_req_valid = 1'b1; bus.r_req_addr = a; r_exp = e;
    end
    forever begin
      @(negedge clock);
      if (wr ? bus.w_req_ready : bus.r_req_ready) break;
      waits++;
      if (waits > 50) begin
        chk("handshake_timeout", wr ? bus.w_req_ready : bus.r_req_ready, 1);
        break;
      end
    end
    @(posedge clock); #1;
    bus.w_req_valid = 1'b0;
    bus.r_req_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  typedef struct { bit wr; logic [7:0] addr; logic [19:0] data; logic [9:0] mask; logic [19:0] exp; } vec_t;
  vec_t vecs[13];

  initial begin
    #20000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.w_req_valid = 1'b0; bus.w_req_addr = '0; bus.w_req_data = '0; bus.w_req_mask = '0;
    bus.r_req_valid = 1'b0; bus.r_req_addr = '0;
    r_exp = '0;

    vecs[0]  = '{1'b1, 8'h12, 20'hABCDE, 10'h3FF, 20'h0};
    vecs[1]  = '{1'b0, 8'h12, 20'h0,     10'h0,   20'hABCDE};
    vecs[2]  = '{1'b1, 8'h12, 20'h00000, 10'h001, 20'h0};
    vecs[3]  = '{1'b0, 8'h12, 20'h0,     10'h0,   20'hABCDC};
    vecs[4]  = '{1'b1, 8'hFF, 20'h55555, 10'h3FF, 20'h0};
    vecs[5]  = '{1'b1, 8'hFF, 20'hFFFFF, 10'h200, 20'h0};
    vecs[6]  = '{1'b0, 8'hFF, 20'h0,     10'h0,   20'hD5555};
    vecs[7]  = '{1'b0, 8'h00, 20'h0,     10'h0,   20'h00000};
    vecs[8]  = '{1'b1, 8'h05, 20'h11111, 10'h3FF, 20'h0};
    vecs[9]  = '{1'b0, 8'h05, 20'h0,     10'h0,   20'h11111};
    vecs[10] = '{1'b0, 8'h12, 20'h0,     10'h0,   20'hABCDC};
    vecs[11] = '{1'b1, 8'h80, 20'h0F0F0, 10'h000, 20'h0};
    vecs[12] = '{1'b0, 8'h80, 20'h0,     10'h0,   20'h00000};

    do_reset();
    sweep_check(256);
    post_init();

    foreach (vecs[i]) issue(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].mask, vecs[i].exp);
    idle_cycles(2);

    // Colliding write and read: write wins, read follows next cycle.
    bus.w_req_valid = 1'b1; bus.w_req_addr = 8'h20; bus.w_req_data = 20'h33333; bus.w_req_mask = 10'h3FF;
    bus.r_req_valid = 1'b1; bus.r_req_addr = 8'h20; r_exp = 20'h33333;
    @(negedge clock);
    chk("col_r_ready", bus.r_req_ready, 0);
    chk("col_w_ready", bus.w_req_ready, 1);
    chk("col_w_en", sram_en, 1);
    chk("col_w_wmode", sram_wmode, 1);
    chk("col_w_addr", sram_addr, 8'h20);
    chk("col_w_wdata", sram_wdata, 20'h33333);
    @(posedge clock); #1;
    bus.w_req_valid = 1'b0;
    @(negedge clock);
    chk("col_r_ready2", bus.r_req_ready, 1);
    chk("col_r_en", sram_en, 1);
    chk("col_r_wmode", sram_wmode, 0);
    chk("col_r_addr", sram_addr, 8'h20);
    chk("col_r_wmask", sram_wmask, 0);
    @(posedge clock); #1;
    bus.r_req_valid = 1'b0;
    @(negedge clock);
    chk("col_resp_valid", bus.r_resp_valid, 1);
    chk("col_resp_data", bus.r_resp_data, 20'h33333);
    chk("col_idle_en", sram_en, 0);
    @(posedge clock); #1;

    // Hold across idle time and a write to the last-read address.
    issue(1'b0, 8'h05, 20'h0, 10'h0, 20'h11111);
    idle_cycles(10);
    issue(1'b1, 8'h05, 20'h22222, 10'h3FF, 20'h0);
    @(negedge clock);
    chk("hold_after_write", bus.r_resp_data, 20'h11111);
    chk("hold_no_pulse", bus.r_resp_valid, 0);
    @(posedge clock); #1;
    idle_cycles(4);

    // Read then write of the same address on consecutive cycles.
    issue(1'b0, 8'h05, 20'h0, 10'h0, 20'h22222);
    issue(1'b1, 8'h05, 20'h44444, 10'h3FF, 20'h0);
    idle_cycles(2);
    issue(1'b0, 8'h05, 20'h0, 10'h0, 20'h44444);
    idle_cycles(3);

    // Reset partway through the sweep.
    do_reset();
    sweep_check(101);
    do_reset();
    sweep_check(256);
    post_init();

    // Reset with a read in flight.
    issue(1'b0, 8'h05, 20'h0, 10'h0, 20'h0);
    reset = 1'b1;
    @(negedge clock);
    chk("flight_rvalid", bus.r_resp_valid, 0);
    chk("flight_rdata", bus.r_resp_data, 0);
    @(posedge clock);
    @(posedge clock); #1;
    reset = 1'b0;
    sweep_check(256);
    post_init();
    idle_cycles(3);

    issue(1'b0, 8'h05, 20'h0, 10'h0, 20'h00000);
    issue(1'b0, 8'h12, 20'h0, 10'h0, 20'h00000);
    idle_cycles(3);
    chk("sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
